instr_realign_wide: RTL and testbench

Parametrised fetch-line realigner between the instruction cache and the instruction queue. It splits one fetch line of FETCH_WIDTH bits into up to FETCH_WIDTH/16 RISC-V instructions, mixing 16-bit RVC and 32-bit encodings. It carries a straddling 32-bit instruction's low half across lines and checks that the carried half matches the address of the next fetch. Outputs are registered behind a valid/ready stage so the instruction queue can apply backpressure.

---
 rtl/instr_realign_wide_if.sv | 36 +++
 rtl/instr_realign_wide.sv | 168 ++++++++++++++++
 tb/tb_instr_realign_wide.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_realign_wide_if.sv
// Fetch-line / instruction-queue bus of the instruction realigner.
//   flush_i, valid_i, address_i, data_i : fetch side into the realigner
//   ready_o                             : fetch line accepted when valid_i & ready_o
//   valid_o, addr_o, instr_o,
//   instr_is_compressed_o,
//   serving_unaligned_o                 : registered per-lane instructions
//   ready_i                             : instruction queue consumes all valid lanes
// Modports: slave = realigner view, master = fetch/queue environment view.
interface instr_realign_wide_if #(
  parameter int unsigned FETCH_WIDTH = 64,
  parameter int unsigned VLEN        = 64
);
  localparam int unsigned NR_SLOTS = FETCH_WIDTH / 16;

  logic                     flush_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [VLEN-1:0]          address_i;
  logic [FETCH_WIDTH-1:0]   data_i;
  logic [NR_SLOTS-1:0]      valid_o;
  logic                     ready_i;
  logic [NR_SLOTS*VLEN-1:0] addr_o;
  logic [NR_SLOTS*32-1:0]   instr_o;
  logic [NR_SLOTS-1:0]      instr_is_compressed_o;
  logic                     serving_unaligned_o;

  modport slave (
    input  flush_i, valid_i, address_i, data_i, ready_i,
    output ready_o, valid_o, addr_o, instr_o, instr_is_compressed_o, serving_unaligned_o
  );

  modport master (
    output flush_i, valid_i, address_i, data_i, ready_i,
    input  ready_o, valid_o, addr_o, instr_o, instr_is_compressed_o, serving_unaligned_o
  );
endinterface

// File: rtl/instr_realign_wide.sv
// Fetch-line realigner: splits a FETCH_WIDTH-bit fetch line into up to
// FETCH_WIDTH/16 RISC-V instructions and registers them behind a valid/ready
// stage toward the instruction queue.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    instr_realign_wide_if.slave (fetch line in, per-lane instructions out)
// Parameters FETCH_WIDTH (32/64/128) and VLEN must match the bus interface.
// Optional feature macro INSTR_REALIGN_RVC_EN: when defined, 16-bit RVC
// decoding and the cross-line carry of a straddling 32-bit low half are built;
// when undefined every slot pair is one 32-bit instruction.
module instr_realign_wide #(
  parameter int unsigned FETCH_WIDTH = 64,
  parameter int unsigned VLEN        = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  instr_realign_wide_if.slave bus
);
  localparam int unsigned NR_SLOTS = FETCH_WIDTH / 16;
  localparam int unsigned OFFS     = $clog2(FETCH_WIDTH / 8);
  localparam int unsigned LW       = $clog2(NR_SLOTS + 1);

  logic [NR_SLOTS-1:0][15:0]     slot;
  logic [OFFS-2:0]               s0;
  logic [VLEN-1:0]               base;
  logic                          accept;
  logic                          unused_addr_lsb;

  logic [NR_SLOTS-1:0]           lane_v_d;
  logic [NR_SLOTS-1:0][31:0]     lane_i_d;
  logic [NR_SLOTS-1:0][VLEN-1:0] lane_a_d;
  logic [LW-1:0]                 nl;

  logic [NR_SLOTS-1:0]           valid_q;
  logic [NR_SLOTS-1:0][31:0]     instr_q;
  logic [NR_SLOTS-1:0][VLEN-1:0] addr_q;

  assign slot            = bus.data_i;
  assign s0              = bus.address_i[OFFS-1:1];
  assign base            = {bus.address_i[VLEN-1:OFFS], {OFFS{1'b0}}};
  assign unused_addr_lsb = bus.address_i[0];

  // An empty register (no valid lane) never blocks the fetch side.
  assign bus.ready_o = ~|valid_q | bus.ready_i;
  assign accept      = bus.valid_i & bus.ready_o & ~bus.flush_i;

`ifdef INSTR_REALIGN_RVC_EN
  logic [NR_SLOTS-1:0] lane_c_d;
  logic                skip;
  logic                carry_hit;
  logic                serve_d;
  logic                carry_v_d, carry_v_q;
  logic [15:0]         carry_i_d, carry_i_q;
  logic [VLEN-1:0]     carry_a_d, carry_a_q;
  logic [NR_SLOTS-1:0] comp_q;
  logic                serve_q;

  always_comb begin
    lane_v_d  = '0;
    lane_c_d  = '0;
    lane_i_d  = '0;
    lane_a_d  = '0;
    nl        = '0;
    skip      = 1'b0;
    serve_d   = 1'b0;
    carry_v_d = 1'b0;
    carry_i_d = '0;
    carry_a_d = '0;
    carry_hit = carry_v_q && (bus.address_i == carry_a_q + VLEN'(2));
    // Lane 0 completes the carried low half with the first useful slot.
    if (carry_hit) begin
      lane_v_d[0] = 1'b1;
      lane_i_d[0] = {slot[s0], carry_i_q};
      lane_a_d[0] = carry_a_q;
      serve_d     = 1'b1;
      nl          = LW'(1);
    end
    for (int unsigned k = 0; k < NR_SLOTS; k++) begin
      if (k >= 32'(s0) && !(carry_hit && k == 32'(s0))) begin
        if (skip) begin
          skip = 1'b0;  // upper half of the previous 32-bit instruction
        end else if (slot[k][1:0] != 2'b11) begin
          lane_v_d[nl] = 1'b1;
          lane_c_d[nl] = 1'b1;
          lane_i_d[nl] = {16'h0000, slot[k]};
          lane_a_d[nl] = base + VLEN'(2 * k);
          nl           = nl + LW'(1);
        end else if (k + 1 < NR_SLOTS) begin
          lane_v_d[nl] = 1'b1;
          lane_i_d[nl] = {slot[k+1], slot[k]};
          lane_a_d[nl] = base + VLEN'(2 * k);
          nl           = nl + LW'(1);
          skip         = 1'b1;
        end else begin
          carry_v_d = 1'b1;
          carry_i_d = slot[k];
          carry_a_d = base + VLEN'(2 * k);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      carry_v_q <= 1'b0;
      carry_i_q <= '0;
      carry_a_q <= '0;
      comp_q    <= '0;
      serve_q   <= 1'b0;
    end else if (bus.flush_i) begin
      carry_v_q <= 1'b0;
      serve_q   <= 1'b0;
    end else if (accept) begin
      carry_v_q <= carry_v_d;
      carry_i_q <= carry_i_d;
      carry_a_q <= carry_a_d;
      comp_q    <= lane_c_d;
      serve_q   <= serve_d;
    end else if (bus.ready_i) begin
      serve_q   <= 1'b0;
    end
  end

  assign bus.instr_is_compressed_o = comp_q;
  assign bus.serving_unaligned_o   = serve_q;
`else
  // Without RVC, address_i[1] is ignored: decoding starts on a slot pair.
  always_comb begin
    lane_v_d = '0;
    lane_i_d = '0;
    lane_a_d = '0;
    nl       = '0;
    for (int unsigned j = 0; j < NR_SLOTS / 2; j++) begin
      if (j >= (32'(s0) >> 1)) begin
        lane_v_d[nl] = 1'b1;
        lane_i_d[nl] = {slot[2*j+1], slot[2*j]};
        lane_a_d[nl] = base + VLEN'(4 * j);
        nl           = nl + LW'(1);
      end
    end
  end

  assign bus.instr_is_compressed_o = '0;
  assign bus.serving_unaligned_o   = 1'b0;
`endif

  // Retire/flush only drop the valid mask; lane payloads hold until the next load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      instr_q <= '0;
      addr_q  <= '0;
    end else if (bus.flush_i) begin
      valid_q <= '0;
    end else if (accept) begin
      valid_q <= lane_v_d;
      instr_q <= lane_i_d;
      addr_q  <= lane_a_d;
    end else if (bus.ready_i) begin
      valid_q <= '0;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.instr_o = instr_q;
  assign bus.addr_o  = addr_q;
endmodule

// File: tb/tb_instr_realign_wide.sv
// Self-checking bench for instr_realign_wide (FETCH_WIDTH=64, VLEN=64).
// A queue-based decode model predicts the output register every cycle; directed
// lines carry hand-computed literal expectations. Follows INSTR_REALIGN_RVC_EN.
module tb_instr_realign_wide;
  localparam int FW = 64;
  localparam int VL = 64;
  localparam int NS = FW / 16;

  logic clk = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_err    = 0;

  instr_realign_wide_if #(.FETCH_WIDTH(FW), .VLEN(VL)) bus ();

  instr_realign_wide #(.FETCH_WIDTH(FW), .VLEN(VL)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Expected output register and carry state.
  logic [NS-1:0] e_valid;
  logic [NS-1:0] e_comp;
  logic          e_serve;
  logic [31:0]   e_instr [NS];
  logic [VL-1:0] e_addr  [NS];
`ifdef INSTR_REALIGN_RVC_EN
  logic          m_cv;
  logic [15:0]   m_ci;
  logic [VL-1:0] m_ca;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] li(input int i);
    return bus.instr_o[32*i +: 32];
  endfunction

  function automatic logic [63:0] la(input int i);
    return bus.addr_o[64*i +: 64];
  endfunction

  task automatic model_clear_lanes();
    e_valid = '0;
    e_comp  = '0;
    e_serve = 1'b0;
    for (int i = 0; i < NS; i++) begin
      e_instr[i] = '0;
      e_addr[i]  = '0;
    end
  endtask

  // Decode one accepted line: the line is a list of half-words starting at the
  // fetch address; instructions are popped off the front of that list.
  task automatic model_accept(input logic [VL-1:0] a, input logic [FW-1:0] d);
    logic [VL-1:0] base;
    int            s0;
    int            n;
`ifdef INSTR_REALIGN_RVC_EN
    logic [15:0]   hw [$];
    logic [VL-1:0] ha [$];
    logic [15:0]   h;
    logic [VL-1:0] h_addr;
`endif
    base = a & ~VL'(FW / 8 - 1);
    s0   = int'((a - base) >> 1);
    n    = 0;
    model_clear_lanes();
`ifdef INSTR_REALIGN_RVC_EN
    if (m_cv && a == m_ca + 2) begin
      e_valid[0] = 1'b1;
      e_instr[0] = {d[16*s0 +: 16], m_ci};
      e_addr[0]  = m_ca;
      e_serve    = 1'b1;
      n          = 1;
      s0++;
    end
    m_cv = 1'b0;
    for (int k = s0; k < NS; k++) begin
      hw.push_back(d[16*k +: 16]);
      ha.push_back(base + VL'(2 * k));
    end
    while (hw.size() > 0) begin
      h      = hw.pop_front();
      h_addr = ha.pop_front();
      if (h[1:0] != 2'b11) begin
        e_valid[n] = 1'b1;
        e_comp[n]  = 1'b1;
        e_instr[n] = {16'h0000, h};
        e_addr[n]  = h_addr;
        n++;
      end else if (hw.size() > 0) begin
        e_valid[n] = 1'b1;
        e_instr[n] = {hw.pop_front(), h};
        e_addr[n]  = h_addr;
        void'(ha.pop_front());
        n++;
      end else begin
        m_cv = 1'b1;
        m_ci = h;
        m_ca = h_addr;
      end
    end
`else
    for (int j = s0 / 2; j < NS / 2; j++) begin
      e_valid[n] = 1'b1;
      e_instr[n] = d[32*j +: 32];
      e_addr[n]  = base + VL'(4 * j);
      n++;
    end
`endif
  endtask

  // Model update on every rising edge from the inputs held across it.
  initial forever begin
    @(posedge clk);
    if (rst_i) begin
      model_clear_lanes();
`ifdef INSTR_REALIGN_RVC_EN
      m_cv = 1'b0;
`endif
    end else if (bus.flush_i) begin
      e_valid = '0;
      e_serve = 1'b0;
`ifdef INSTR_REALIGN_RVC_EN
      m_cv = 1'b0;
`endif
    end else if (bus.valid_i && (~|e_valid || bus.ready_i)) begin
      model_accept(bus.address_i, bus.data_i);
    end else if (bus.ready_i) begin
      e_valid = '0;
      e_serve = 1'b0;
    end
  end

  // Compare on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst_i) begin
      chk("ready_o", 64'(bus.ready_o), 64'(~|e_valid | bus.ready_i));
      chk("valid_o", 64'(bus.valid_o), 64'(e_valid));
      chk("compressed", 64'(bus.instr_is_compressed_o), 64'(e_comp));
      chk("serving_unaligned", 64'(bus.serving_unaligned_o), 64'(e_serve));
      for (int i = 0; i < NS; i++) begin
        chk($sformatf("instr[%0d]", i), 64'(li(i)), 64'(e_instr[i]));
        chk($sformatf("addr[%0d]", i), la(i), e_addr[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [VL-1:0] a, input logic [FW-1:0] d);
    bus.valid_i   = 1'b1;
    bus.address_i = a;
    bus.data_i    = d;
    tick();
    bus.valid_i   = 1'b0;
  endtask

  initial begin
    rst_i         = 1'b1;
    bus.flush_i   = 1'b0;
    bus.valid_i   = 1'b0;
    bus.ready_i   = 1'b1;
    bus.address_i = '0;
    bus.data_i    = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    chk("reset_valid", 64'(bus.valid_o), 64'h0);
    chk("reset_instr", 64'(|bus.instr_o), 64'h0);
    chk("reset_addr", 64'(|bus.addr_o), 64'h0);
    chk("reset_ready", 64'(bus.ready_o), 64'h1);
    chk("reset_serving", 64'(bus.serving_unaligned_o), 64'h0);

`ifdef INSTR_REALIGN_RVC_EN
    send(64'h1000, 64'h0001_0001_0001_0001);
    chk("allrvc_valid", 64'(bus.valid_o), 64'hF);
    chk("allrvc_comp", 64'(bus.instr_is_compressed_o), 64'hF);
    for (int i = 0; i < NS; i++) begin
      chk("allrvc_addr", la(i), 64'h1000 + 64'(2 * i));
      chk("allrvc_instr", 64'(li(i)), 64'h1);
    end

    send(64'h2000, 64'h0003_0001_0000_0013);
    chk("straddle1_valid", 64'(bus.valid_o), 64'h3);
    chk("straddle1_i0", 64'(li(0)), 64'h13);
    chk("straddle1_a0", la(0), 64'h2000);
    chk("straddle1_i1", 64'(li(1)), 64'h1);
    chk("straddle1_a1", la(1), 64'h2004);

    send(64'h2008, 64'h0001_0001_0001_ABCD);
    chk("straddle2_valid", 64'(bus.valid_o), 64'hF);
    chk("straddle2_i0", 64'(li(0)), 64'hABCD0003);
    chk("straddle2_a0", la(0), 64'h2006);
    chk("straddle2_serve", 64'(bus.serving_unaligned_o), 64'h1);
    chk("straddle2_comp", 64'(bus.instr_is_compressed_o), 64'hE);
    chk("straddle2_a3", la(3), 64'h200E);

    send(64'h3006, 64'h0001_0000_0000_0000);
    chk("offset_valid", 64'(bus.valid_o), 64'h1);
    chk("offset_a0", la(0), 64'h3006);
    send(64'h3006, 64'h0003_0000_0000_0000);
    chk("offset_empty_valid", 64'(bus.valid_o), 64'h0);

    send(64'h2000, 64'h0003_0001_0000_0013);
    send(64'h5000, 64'h0001_0001_0001_0001);
    chk("mismatch_valid", 64'(bus.valid_o), 64'hF);
    chk("mismatch_a0", la(0), 64'h5000);
    chk("mismatch_i0", 64'(li(0)), 64'h1);
    chk("mismatch_serve", 64'(bus.serving_unaligned_o), 64'h0);

    send(64'h2000, 64'h0003_0001_0000_0013);
    bus.flush_i   = 1'b1;
    bus.valid_i   = 1'b1;
    bus.address_i = 64'h2008;
    bus.data_i    = 64'h0001_0001_0001_ABCD;
    tick();
    bus.flush_i   = 1'b0;
    bus.valid_i   = 1'b0;
    chk("flush_valid", 64'(bus.valid_o), 64'h0);
    send(64'h2008, 64'h0001_0001_0001_ABCD);
    chk("postflush_valid", 64'(bus.valid_o), 64'hF);
    chk("postflush_i0", 64'(li(0)), 64'h0000ABCD);
    chk("postflush_a0", la(0), 64'h2008);
    chk("postflush_serve", 64'(bus.serving_unaligned_o), 64'h0);
`else
    send(64'h1000, 64'h0001_0001_0001_0001);
    chk("pair_valid", 64'(bus.valid_o), 64'h3);
    chk("pair_i0", 64'(li(0)), 64'h00010001);
    chk("pair_a0", la(0), 64'h1000);
    chk("pair_i1", 64'(li(1)), 64'h00010001);
    chk("pair_a1", la(1), 64'h1004);
    chk("pair_comp", 64'(bus.instr_is_compressed_o), 64'h0);

    send(64'h1006, 64'h1234_5678_9ABC_DEF3);
    chk("pair_off_valid", 64'(bus.valid_o), 64'h1);
    chk("pair_off_i0", 64'(li(0)), 64'h12345678);
    chk("pair_off_a0", la(0), 64'h1004);

    send(64'h1002, 64'h1111_2222_3333_4444);
    chk("pair_a1_valid", 64'(bus.valid_o), 64'h3);
    chk("pair_a1_i0", 64'(li(0)), 64'h33334444);
    chk("pair_a1_a0", la(0), 64'h1000);
    chk("pair_a1_i1", 64'(li(1)), 64'h11112222);

    send(64'h2000, 64'h0003_0001_0000_0013);
    bus.flush_i = 1'b1;
    bus.valid_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    chk("flush_valid", 64'(bus.valid_o), 64'h0);
`endif

    // Backpressure: line A loads, line B waits at the input for 3 stall cycles.
    tick();
    bus.ready_i = 1'b0;
    send(64'h1000, 64'h0001_0001_0001_0001);
    bus.valid_i   = 1'b1;
    bus.address_i = 64'h4000;
    bus.data_i    = 64'h0001_0001_0001_0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_ready", 64'(bus.ready_o), 64'h0);
      chk("stall_a0", la(0), 64'h1000);
`ifdef INSTR_REALIGN_RVC_EN
      chk("stall_valid", 64'(bus.valid_o), 64'hF);
`else
      chk("stall_valid", 64'(bus.valid_o), 64'h3);
`endif
    end
    bus.ready_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    chk("release_a0", la(0), 64'h4000);
    chk("release_valid_nonzero", 64'(|bus.valid_o), 64'h1);

    // Flush in the middle of a stall.
    tick();
    bus.ready_i = 1'b0;
    send(64'h6000, 64'h0001_0001_0001_0001);
    tick();
    chk("midstall_ready", 64'(bus.ready_o), 64'h0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("midstall_flush_valid", 64'(bus.valid_o), 64'h0);
    bus.ready_i = 1'b1;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
